mac_group_scheduler: RTL and testbench
======================================

Name: mac_group_scheduler

Overview:
- Sequences one dot-product job on the 16-lane signed 8-bit multiplier group.
- Serially loads 16 lane weights, then streams cfg_len input samples into the group with stall support.
- Issues clear, enable and last strobes to the downstream 32-bit lane accumulators, time-aligned to the group's registered product output.
- Sits between the input/weight buffers and the multiplier group plus accumulator bank.

Parameters:
LANES, 16, number of multiplier lanes (weights per job)
DW, 8, sample and weight width (signed)
LEN_W, 16, width of the sample-count field
MUL_LAT, 1, product latency of the multiplier group in cycles (≥1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
cfg_start  in  1  start pulse; ignored unless busy=0
cfg_len  in  LEN_W  samples per job; captured at the accepted cfg_start
busy  out  1  high from the accepted start until done
done  out  1  single-cycle job-complete pulse
w_valid  in  1  weight byte valid
w_ready  out  1  weight byte accepted when w_valid&w_ready
w_data  in  DW  weight byte; lane 0 first
x_valid  in  1  input sample valid
x_ready  out  1  sample accepted when x_valid&x_ready
x_data  in  DW  input sample
weights_o  out  LANES*DW  lane k weight at bits [k*DW +: DW]; drives the group's weight inputs
mg_data_o  out  DW  sample to the multiplier group
mg_valid_o  out  1  valid to the multiplier group
acc_clr  out  1  clears the accumulators
acc_en  out  1  accumulators add the current products
acc_last  out  1  marks the final acc_en of the job

Behaviour:
- Reset (async, rst=1):
  - State IDLE; counters zero.
  - All outputs 0, including weights_o, mg_data_o, done and the strobes.
  - Reset mid-job abandons the job; no done is produced.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - busy=0; w_ready=x_ready=0.
  - On cfg_start: capture cfg_len, go to LOAD_W; busy=1 from the next cycle.
- LOAD_W:
  - w_ready=1. Each handshake writes w_data into lane widx; widx then increments.
  - On the handshake with widx=LANES-1, go to STREAM.
  - acc_clr pulses for exactly one cycle: the first STREAM cycle.
- STREAM:
  - x_ready=1 while remaining>0. Each handshake registers mg_data_o<=x_data and sets mg_valid_o=1 the next cycle.
  - Cycles without a handshake give mg_valid_o=0 (bubble); mg_data_o holds its last value.
  - After the handshake that brings remaining to 0, go to DRAIN.
  - cfg_len=0: STREAM lasts one cycle with x_ready=0, then DRAIN; no acc_en or acc_last occurs.
- Alignment:
  - acc_en is mg_valid_o delayed by MUL_LAT registers, so it coincides with the group's product outputs.
  - acc_last is the final sample's flag carried through the same delay line.
- DRAIN:
  - Counts MUL_LAT+1 cycles, so the last acc_en/acc_last has been emitted, then goes to DONE.
- DONE:
  - done=1 for one cycle, busy=0 in the same cycle, then IDLE.
  - cfg_start in the DONE cycle is ignored.
- Weight stability:
  - weights_o changes only by LOAD_W handshakes.
  - It holds its value through STREAM, DRAIN and after the job, until the next job's LOAD_W.
- Simultaneous events:
  - cfg_start while busy is ignored and does not reload cfg_len.
  - x_valid outside STREAM is not accepted.
  - w_valid outside LOAD_W is not accepted.
- Widths: remaining is LEN_W bits; widx is clog2(LANES) bits; no arithmetic on data.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE..DONE).
  - Constants LANES=16, DW=8, and the 32-bit accumulator width used by the accumulator bank.
- One sub-module: mac_valid_delay, a MUL_LAT-deep shift register for {valid, last}, reset to 0. It is reused by the accumulator bank.

Test Plan:
1. Basic job:
   - Stimulus: weights 1..16 loaded back-to-back; cfg_len=4; samples 3,-2,5,7 with no stalls.
   - Response: weights_o lane k = k+1; acc_clr pulses once before the first acc_en; four consecutive acc_en; acc_last on the 4th; done 1 cycle later (MUL_LAT=1); busy deasserts with done.
2. Stalls:
   - Stimulus: cfg_len=3; x_valid toggled 1,0,0,1,0,1; w_valid gapped every other cycle.
   - Response: mg_valid_o pattern 1,0,0,1,0,1 delayed 1 cycle; acc_en mirrors it at +MUL_LAT; weights are complete only after 16 handshakes.
3. Zero length:
   - Stimulus: cfg_len=0.
   - Response: 16 weight handshakes; acc_clr=1 once; no acc_en or acc_last; done pulses; x_ready never 1.
4. Ignored start:
   - Stimulus: cfg_start with cfg_len=9 during STREAM of a cfg_len=2 job.
   - Response: exactly 2 samples accepted, a single done, and the next job is unaffected.
5. Reset mid-job:
   - Stimulus: rst asserted during STREAM after 2 of 5 samples.
   - Response: all outputs 0 immediately (async), weights_o=0, no done; a fresh job afterwards completes normally.
6. Latency parameter:
   - Stimulus: MUL_LAT=3, cfg_len=2.
   - Response: acc_en rises 3 cycles after mg_valid_o; done occurs exactly 1 cycle after acc_last.

Source files
------------

// File: rtl/mac_group_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : mac_group_scheduler_pkg
// Brief  : Shared state encoding and sizing constants for the MAC group
//          scheduler and the accumulator bank.
// Rev    : 1.0  initial release
// ============================================================================
package mac_group_scheduler_pkg;

  localparam int MG_LANES = 16;  // multiplier lanes in the group
  localparam int MG_DW    = 8;   // signed sample/weight width
  localparam int ACC_W    = 32;  // lane accumulator width in the accumulator bank

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mac_valid_delay.sv
`default_nettype none
// ============================================================================
// Module : mac_valid_delay
// Brief  : DEPTH-stage shift register for sideband flags ({valid, last}),
//          used to align control strobes with the multiplier group products.
// Rev    : 1.0  initial release
// ============================================================================
module mac_valid_delay
  import mac_group_scheduler_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  generate
    if (DEPTH == 1) begin : g_single
      // Single register stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage <= '0;
        else     stage <= din;
      end
    end else begin : g_chain
      // Shift new flags into stage 0, oldest flags leave from the top stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage <= '0;
        else     stage <= {stage[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mac_group_scheduler.sv
`default_nettype none
// ============================================================================
// Module : mac_group_scheduler
// Brief  : Sequences one dot-product job: serial weight load into 16 lanes,
//          stall-tolerant sample streaming into the multiplier group, and
//          clear/enable/last strobes aligned to the product latency.
// Rev    : 1.0  initial release
// ============================================================================
module mac_group_scheduler
  import mac_group_scheduler_pkg::*;
#(
  parameter int LANES   = MG_LANES,
  parameter int DW      = MG_DW,
  parameter int LEN_W   = 16,
  parameter int MUL_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [LEN_W-1:0]    cfg_len,
  output logic                busy,
  output logic                done,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [DW-1:0]       w_data,
  input  logic                x_valid,
  output logic                x_ready,
  input  logic [DW-1:0]       x_data,
  output logic [LANES*DW-1:0] weights_o,
  output logic [DW-1:0]       mg_data_o,
  output logic                mg_valid_o,
  output logic                acc_clr,
  output logic                acc_en,
  output logic                acc_last
);

  localparam int WIDX_W = $clog2(LANES);
  localparam int DRN_W  = $clog2(MUL_LAT + 2);

  state_t             state;
  state_t             state_nxt;
  logic [LEN_W-1:0]   remaining;
  logic [WIDX_W-1:0]  widx;
  logic [DRN_W-1:0]   drain_cnt;
  logic               mg_last;
  logic               w_take;
  logic               x_take;
  logic               w_final;
  logic               x_final;

  // Handshakes are qualified by state directly so the FSM does not loop
  // through its own ready outputs.
  assign w_take  = w_valid && (state == LOAD_W);
  assign x_take  = x_valid && (state == STREAM) && (remaining != '0);
  assign w_final = w_take && (widx == WIDX_W'(LANES - 1));
  assign x_final = x_take && (remaining == LEN_W'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    w_ready   = 1'b0;
    x_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) state_nxt = LOAD_W;
      end
      LOAD_W: begin
        busy    = 1'b1;
        w_ready = 1'b1;
        if (w_final) state_nxt = STREAM;
      end
      STREAM: begin
        busy    = 1'b1;
        x_ready = (remaining != '0);
        // A zero-length job spends exactly one cycle here.
        if ((remaining == '0) || x_final) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // MUL_LAT+1 cycles lets the final product strobe leave the delay line.
        if (drain_cnt == DRN_W'(MUL_LAT)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job length capture and per-sample countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             remaining <= '0;
    else if ((state == IDLE) && cfg_start) remaining <= cfg_len;
    else if (x_take)                     remaining <= remaining - 1'b1;
  end

  // Weight lane index and weight register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx      <= '0;
      weights_o <= '0;
    end else if (state == IDLE) begin
      widx <= '0;
    end else if (w_take) begin
      widx                       <= widx + 1'b1;
      weights_o[widx*DW +: DW]   <= w_data;
    end
  end

  // Sample register toward the multiplier group; data holds across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mg_data_o  <= '0;
      mg_valid_o <= 1'b0;
      mg_last    <= 1'b0;
    end else begin
      if (x_take) mg_data_o <= x_data;
      mg_valid_o <= x_take;
      mg_last    <= x_final;
    end
  end

  // Accumulator clear on the first STREAM cycle, after the final weight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_clr <= 1'b0;
    else     acc_clr <= w_final;
  end

  // Drain cycle counter, idle at zero outside DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  drain_cnt <= '0;
    else if (state == DRAIN)  drain_cnt <= drain_cnt + 1'b1;
    else                      drain_cnt <= '0;
  end

  mac_valid_delay #(
    .DEPTH (MUL_LAT),
    .WIDTH (2)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({mg_valid_o, mg_last}),
    .dout ({acc_en, acc_last})
  );

endmodule
`default_nettype wire

// File: tb/tb_mac_group_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_mac_group_scheduler
// Brief  : Scoreboard bench; drives a MUL_LAT=1 and a MUL_LAT=3 instance with
//          identical directed stimulus.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mac_group_scheduler;

  typedef struct {
    int           len;
    logic [127:0] w;
  } job_t;

  localparam int LAT [2] = '{1, 3};

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [15:0] cfg_len;
  logic        w_valid;
  logic [7:0]  w_data;
  logic        x_valid;
  logic [7:0]  x_data;
  logic        x_last;

  logic         busy [2], done [2], w_ready [2], x_ready [2];
  logic         mg_valid [2], acc_clr [2], acc_en [2], acc_last [2];
  logic [7:0]   mg_data [2];
  logic [127:0] weights [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  job_t       jobq [2][$];
  logic [7:0] sq [2][$];

  logic [7:0] hs_hist [2];
  logic [7:0] last_hist [2];
  logic       clr_q [2];
  logic [3:0] wcnt [2];
  int         xhs [2];
  int         whs [2];

  always #5 clk = ~clk;

  mac_group_scheduler #(.LANES(16), .DW(8), .LEN_W(16), .MUL_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .busy(busy[0]), .done(done[0]),
    .w_valid(w_valid), .w_ready(w_ready[0]), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready[0]), .x_data(x_data),
    .weights_o(weights[0]), .mg_data_o(mg_data[0]), .mg_valid_o(mg_valid[0]),
    .acc_clr(acc_clr[0]), .acc_en(acc_en[0]), .acc_last(acc_last[0])
  );

  mac_group_scheduler #(.LANES(16), .DW(8), .LEN_W(16), .MUL_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .busy(busy[1]), .done(done[1]),
    .w_valid(w_valid), .w_ready(w_ready[1]), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready[1]), .x_data(x_data),
    .weights_o(weights[1]), .mg_data_o(mg_data[1]), .mg_valid_o(mg_valid[1]),
    .acc_clr(acc_clr[1]), .acc_en(acc_en[1]), .acc_last(acc_last[1])
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Cycle counter used for strobe-to-done spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference history: handshakes seen at each edge, the final-sample flag,
  // and the expected clear after every 16th weight handshake.
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        hs_hist[d]   <= '0;
        last_hist[d] <= '0;
        clr_q[d]     <= 1'b0;
        wcnt[d]      <= '0;
        xhs[d]       <= 0;
        whs[d]       <= 0;
      end else begin
        hs_hist[d]   <= {hs_hist[d][6:0], x_valid & x_ready[d]};
        last_hist[d] <= {last_hist[d][6:0], x_valid & x_ready[d] & x_last};
        clr_q[d]     <= w_valid & w_ready[d] & (wcnt[d] == 4'd15);
        if (w_valid & w_ready[d]) begin
          wcnt[d] <= wcnt[d] + 4'd1;
          whs[d]  <= whs[d] + 1;
        end
        if (x_valid & x_ready[d]) xhs[d] <= xhs[d] + 1;
      end
    end
  end

  // Monitor: compares strobes every cycle and pops the scoreboards when the
  // DUT presents a sample or a job completion.
  int en_cnt [2], clr_cnt [2], last_cnt [2], last_cyc [2], clr_cyc [2];
  int xbase [2], wbase [2];

  always @(negedge clk) begin : mon
    job_t       j;
    logic [7:0] e;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        sq[d].delete();
        jobq[d].delete();
        en_cnt[d] = 0; clr_cnt[d] = 0; last_cnt[d] = 0;
        xbase[d] = 0;  wbase[d] = 0;
      end else begin
        check("mg_valid_align", mg_valid[d], hs_hist[d][0]);
        check("acc_en_align",   acc_en[d],   hs_hist[d][LAT[d]]);
        check("acc_last_align", acc_last[d], last_hist[d][LAT[d]]);
        check("acc_clr_align",  acc_clr[d],  clr_q[d]);
        if (mg_valid[d]) begin
          if (sq[d].size() == 0) fail("mg_valid_unexpected");
          else begin
            e = sq[d].pop_front();
            check("mg_data", mg_data[d], e);
          end
        end
        if (acc_clr[d]) begin clr_cnt[d]++; clr_cyc[d] = cyc; end
        if (acc_en[d]) en_cnt[d]++;
        if (acc_last[d]) begin last_cnt[d]++; last_cyc[d] = cyc; end
        if (done[d]) begin
          if (jobq[d].size() == 0) fail("done_unexpected");
          else begin
            j = jobq[d].pop_front();
            check("done_busy_low",    busy[d], 0);
            check("job_acc_en_count", en_cnt[d], j.len);
            check("job_acc_clr_count", clr_cnt[d], 1);
            check("job_acc_last_count", last_cnt[d], (j.len > 0));
            check("job_x_handshakes", xhs[d] - xbase[d], j.len);
            check("job_w_handshakes", whs[d] - wbase[d], 16);
            check("job_weights",      weights[d], j.w);
            if (j.len > 0) check("done_after_last", cyc - last_cyc[d], 1);
            else           check("done_after_clr",  cyc - clr_cyc[d], LAT[d] + 2);
          end
          en_cnt[d] = 0; clr_cnt[d] = 0; last_cnt[d] = 0;
          xbase[d] = xhs[d]; wbase[d] = whs[d];
        end
      end
    end
  end

  task automatic check_all_zero(input string nm);
    for (int d = 0; d < 2; d++) begin
      check({nm, "_ctl"}, {busy[d], done[d], w_ready[d], x_ready[d], mg_valid[d],
                           acc_clr[d], acc_en[d], acc_last[d], mg_data[d]}, 0);
      check({nm, "_weights"}, weights[d], 0);
    end
  endtask

  // Accept a job, then load 16 weights; x_valid is held high with junk data
  // to confirm samples are refused outside STREAM.
  task automatic start_job(input int len, input logic [7:0] w [16], input bit gap);
    job_t j;
    int   k = 0;
    int   g = 0;
    j.len = len;
    for (int i = 0; i < 16; i++) j.w[i*8 +: 8] = w[i];
    jobq[0].push_back(j);
    jobq[1].push_back(j);
    @(negedge clk);
    cfg_start = 1'b1;
    cfg_len   = 16'(len);
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_len   = 16'd0;
    check("busy_after_start", {busy[0], busy[1]}, 2'b11);
    x_valid = 1'b1;
    x_data  = 8'hEE;
    x_last  = 1'b0;
    while (k < 16 && g < 100) begin
      w_valid = gap ? ((g % 2) == 0) : 1'b1;
      w_data  = w[k];
      if (w_valid && w_ready[0]) k++;
      g++;
      @(negedge clk);
    end
    if (k < 16) fail("weight_load_timeout");
    w_valid = 1'b1;
    w_data  = 8'hCC;
  endtask

  // Offer samples following a valid pattern; optionally pulse cfg_start at
  // offer slot ign_k to confirm it is ignored while busy.
  task automatic stream(input logic [7:0] s [$], input bit v [$], input bit mark_last,
                        input int ign_k);
    int i = 0;
    int k = 0;
    while (i < s.size() && k < 200) begin
      x_valid   = (k < v.size()) ? v[k] : 1'b1;
      x_data    = s[i];
      x_last    = mark_last && (i == s.size() - 1);
      cfg_start = (k == ign_k);
      cfg_len   = (k == ign_k) ? 16'd9 : 16'd0;
      if (x_valid && x_ready[0]) begin
        sq[0].push_back(s[i]);
        sq[1].push_back(s[i]);
        i++;
      end
      k++;
      @(negedge clk);
    end
    if (i < s.size()) fail("stream_timeout");
    cfg_start = 1'b0;
    cfg_len   = 16'd0;
    x_valid   = 1'b0;
    x_last    = 1'b0;
  endtask

  // Wait for both instances to finish; optionally pulse cfg_start in the
  // MUL_LAT=1 instance's DONE cycle.
  task automatic wait_done(input int len, input bit start_in_done);
    bit seen0 = 1'b0;
    bit seen1 = 1'b0;
    int g     = 0;
    if (len == 0) x_valid = 1'b1;
    while (!(seen0 && seen1) && g < 100) begin
      @(negedge clk);
      g++;
      if (len == 0) check("x_ready_len0", {x_ready[0], x_ready[1]}, 0);
      if (done[0] && !seen0) begin
        seen0 = 1'b1;
        if (start_in_done) begin
          cfg_start = 1'b1;
          cfg_len   = 16'd7;
          @(negedge clk);
          g++;
          cfg_start = 1'b0;
          cfg_len   = 16'd0;
          check("start_in_done_ignored", {busy[0], w_ready[0]}, 0);
        end
      end
      if (done[1]) seen1 = 1'b1;
    end
    if (!(seen0 && seen1)) fail("done_timeout");
    x_valid = 1'b0;
    w_valid = 1'b0;
  endtask

  logic [7:0] wa [16];
  logic [7:0] s_t1 [$], s_t2 [$], s_t4 [$], s_t5 [$], s_t5b [$], s_none [$];
  bit         v_t2 [$], v_t4 [$], v_all [$];

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_len = 16'd0;
    w_valid = 1'b0; w_data = 8'd0; x_valid = 1'b0; x_data = 8'd0; x_last = 1'b0;
    s_t1  = '{8'h03, 8'hFE, 8'h05, 8'h07};
    s_t2  = '{8'h11, 8'h80, 8'h7F};
    v_t2  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    s_t4  = '{8'h21, 8'hDE};
    v_t4  = '{1'b1, 1'b0, 1'b1};
    s_t5  = '{8'h41, 8'h42};
    s_t5b = '{8'h0A, 8'hF6, 8'h64};
    #3;
    check_all_zero("reset_state");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic job: weights 1..16, four samples back-to-back.
    for (int k = 0; k < 16; k++) wa[k] = 8'(k + 1);
    start_job(4, wa, 1'b0);
    stream(s_t1, v_all, 1'b1, -1);
    wait_done(4, 1'b1);

    // Stalls on both the weight and sample interfaces.
    for (int k = 0; k < 16; k++) wa[k] = 8'(k * 17 + 5);
    start_job(3, wa, 1'b1);
    stream(s_t2, v_t2, 1'b1, -1);
    wait_done(3, 1'b0);

    // Zero-length job.
    for (int k = 0; k < 16; k++) wa[k] = 8'(8'hA0 + k);
    start_job(0, wa, 1'b0);
    stream(s_none, v_all, 1'b1, -1);
    wait_done(0, 1'b0);

    // Start request during STREAM must not reload the length.
    for (int k = 0; k < 16; k++) wa[k] = 8'(k * 3);
    start_job(2, wa, 1'b0);
    stream(s_t4, v_t4, 1'b1, 1);
    wait_done(2, 1'b0);

    // Reset in STREAM after 2 of 5 samples.
    for (int k = 0; k < 16; k++) wa[k] = 8'h55;
    start_job(5, wa, 1'b0);
    stream(s_t5, v_all, 1'b0, -1);
    w_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_all_zero("reset_mid_job");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_done_after_reset", {done[0], done[1], busy[0], busy[1]}, 0);

    // Fresh job after the aborted one.
    for (int k = 0; k < 16; k++) wa[k] = 8'(16 - k);
    start_job(3, wa, 1'b0);
    stream(s_t5b, v_all, 1'b1, -1);
    wait_done(3, 1'b0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
